// File: rtl/binary_downcounter_pkg.sv
// Shared state encoding and default width for the binary down-counter.
package binary_downcounter_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/binary_downcounter.sv
// Loadable N-bit down-counter with one-shot/periodic modes and a registered zero pulse.
// All outputs come straight from registers; priority per edge is stop > start > count > hold.
module binary_downcounter
  import binary_downcounter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  output logic [N-1:0] count,
  output logic         zero_tick,
  output logic         busy
);

  state_t       state, state_nxt;
  logic [N-1:0] count_nxt;
  logic         zero_tick_nxt;
  logic [N-1:0] reload_reg, reload_nxt;
  logic         mode_reg, mode_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      zero_tick  <= 1'b0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      zero_tick  <= zero_tick_nxt;
      reload_reg <= reload_nxt;
      mode_reg   <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    zero_tick_nxt = 1'b0;
    reload_nxt    = reload_reg;
    mode_nxt      = mode_reg;

    if (stop) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (start) begin
      state_nxt     = RUN;
      count_nxt     = load_val;
      reload_nxt    = load_val;
      mode_nxt      = auto_reload;
      zero_tick_nxt = (load_val == '0);
    end else if (state == RUN && en) begin
      if (count != '0) begin
        count_nxt     = count - N'(1);
        zero_tick_nxt = (count == N'(1));
      end else if (mode_reg) begin
        // A zero reload value keeps the tick asserted on every enabled cycle.
        count_nxt     = reload_reg;
        zero_tick_nxt = (reload_reg == '0);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  assign busy = (state == RUN);

endmodule
